mul_unit: RTL and testbench



---
 rtl/rv_mul_pkg.sv | 30 +++
 rtl/BoothMul.sv | 57 +++++
 rtl/mul_unit.sv | 146 ++++++++++++++
 tb/tb_mul_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mul_pkg.sv
// Shared definitions for the RV32M multiply unit: operation and state encodings,
// operand width and the per-op operand signedness decode.
package rv_mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;

    // MUL takes both operands as unsigned: its low word does not depend on signedness.
    function automatic logic op_a_signed(input mul_op_e o);
        return (o == MUL_OP_MULH) || (o == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input mul_op_e o);
        return (o == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/BoothMul.sv
// Combinational unsigned WxW multiplier: radix-4 Booth partial products reduced
// through a carry-save array and resolved by a single final adder.
module BoothMul #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod
);

    localparam int NPP = W / 2 + 1;

    logic [W+2:0]   bx;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] pp [NPP];
    logic [2:0]     trip;
    logic [2*W-1:0] mult;
    logic [2*W-1:0] sum_v;
    logic [2*W-1:0] carry_v;
    logic [2*W-1:0] sum_n;
    logic [2*W-1:0] carry_n;

    // Two zero bits on top keep the recoding unsigned; the low zero is the implicit b[-1].
    assign bx    = {2'b00, b, 1'b0};
    assign a_ext = {{W{1'b0}}, a};

    always_comb begin
        trip = 3'b000;
        mult = '0;
        for (int i = 0; i < NPP; i++) begin
            trip = bx[2*i +: 3];
            case (trip)
                3'b001, 3'b010: mult = a_ext;
                3'b011:         mult = a_ext << 1;
                3'b100:         mult = -(a_ext << 1);
                3'b101, 3'b110: mult = -a_ext;
                default:        mult = '0;
            endcase
            pp[i] = mult << (2 * i);
        end
    end

    always_comb begin
        sum_v   = '0;
        carry_v = '0;
        sum_n   = '0;
        carry_n = '0;
        for (int i = 0; i < NPP; i++) begin
            sum_n   = sum_v ^ carry_v ^ pp[i];
            carry_n = ((sum_v & carry_v) | (sum_v & pp[i]) | (carry_v & pp[i])) << 1;
            sum_v   = sum_n;
            carry_v = carry_n;
        end
        prod = sum_v + carry_v;
    end

endmodule

// File: rtl/mul_unit.sv
// RV32M multiply unit for the EX stage: sign handling around an unsigned core,
// a four-state sequencer and a one-entry operand/product cache.
module mul_unit #(
    parameter int XLEN     = rv_mul_pkg::XLEN,
    parameter int CACHE_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import rv_mul_pkg::*;

    localparam int PW = 2 * XLEN;

    mul_state_e      state;
    mul_op_e         op_in;
    mul_op_e         op_q;
    mul_op_e         cache_mode;
    logic            a_sgn;
    logic            b_sgn;
    logic            neg;
    logic            neg_q;
    logic            cache_vld;
    logic            cache_hit;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] a_mag_q;
    logic [XLEN-1:0] b_mag_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] cache_rs1;
    logic [XLEN-1:0] cache_rs2;
    logic [PW-1:0]   core_prod;
    logic [PW-1:0]   prod_q;
    logic [PW-1:0]   prod_fix;
    logic [PW-1:0]   cache_prod;

    function automatic logic [XLEN-1:0] pick_half(input mul_op_e o, input logic [PW-1:0] p);
        return (o == MUL_OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    assign op_in = mul_op_e'(op);
    assign a_sgn = op_a_signed(op_in);
    assign b_sgn = op_b_signed(op_in);

    // The most negative value negates to itself, which is already its correct unsigned magnitude.
    assign a_mag = (a_sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    assign b_mag = (b_sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    assign neg   = (a_sgn & rs1[XLEN-1]) ^ (b_sgn & rs2[XLEN-1]);

    // A MUL only needs the low word, which is identical for every cached mode.
    assign cache_hit = (CACHE_EN != 0) && cache_vld
                       && (rs1 == cache_rs1) && (rs2 == cache_rs2)
                       && ((op_in == MUL_OP_MUL) || (op_in == cache_mode));

    BoothMul #(
        .W(XLEN)
    ) u_core (
        .a   (a_mag_q),
        .b   (b_mag_q),
        .prod(core_prod)
    );

    assign prod_fix = neg_q ? -prod_q : prod_q;

    assign stall  = ((state == IDLE) && start) || (state == CALC) || (state == FIX);
    assign done   = (state == DONE);
    assign result = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= MUL_OP_MUL;
            neg_q      <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            prod_q     <= '0;
            result_q   <= '0;
            cache_vld  <= 1'b0;
            cache_rs1  <= '0;
            cache_rs2  <= '0;
            cache_mode <= MUL_OP_MUL;
            cache_prod <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        if (cache_hit) begin
                            result_q <= pick_half(op_in, cache_prod);
                            state    <= DONE;
                        end else begin
                            a_mag_q <= a_mag;
                            b_mag_q <= b_mag;
                            neg_q   <= neg;
                            op_q    <= op_in;
                            rs1_q   <= rs1;
                            rs2_q   <= rs2;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        prod_q <= core_prod;
                        state  <= FIX;
                    end
                end
                FIX: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        result_q <= pick_half(op_q, prod_fix);
                        if (CACHE_EN != 0) begin
                            cache_vld  <= 1'b1;
                            cache_rs1  <= rs1_q;
                            cache_rs2  <= rs2_q;
                            cache_mode <= op_q;
                            cache_prod <= prod_fix;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: directed ops push expected results, a monitor
// pops and compares on every done pulse; the driver checks latency and stall.
module tb_mul_unit;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        stall_nc;
    logic        done_nc;
    logic [31:0] result_nc;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_now = 0;
    int          last_done = 0;
    int          first_done = 0;
    bit          nc_chk = 1'b0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_nm;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    mul_unit #(
        .XLEN(32),
        .CACHE_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .kill(kill), .stall(stall), .done(done), .result(result)
    );

    mul_unit #(
        .XLEN(32),
        .CACHE_EN(0)
    ) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .kill(kill), .stall(stall_nc), .done(done_nc), .result(result_nc)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: result 0x%08h with no op pending", result);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                check(mon_nm, result, mon_exp);
                if (nc_chk) begin
                    check({mon_nm, "_nc_done"}, {31'd0, done_nc}, 32'd1);
                    check({mon_nm, "_nc"}, result_nc, mon_exp);
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int lat, input bit hold,
                          input string nm);
        int cyc = 0;
        int st  = 0;
        bit got = 1'b0;
        exp_q.push_back(want);
        name_q.push_back(nm);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (stall) st++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected one after %0d", nm, cyc, lat);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end else begin
            last_done = cyc_now;
            check({nm, "_latency"}, cyc, lat);
            check({nm, "_stall_cycles"}, st, lat - 1);
        end
        if (!hold) start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = OP_MUL;
        rs1   = '0;
        rs2   = '0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_stall_nc", {31'd0, stall_nc}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_MUL,    32'd7,         32'd6,         32'h0000002A, 4, 1'b0, "mul_7x6");
        run_op(OP_MULH,   32'h80000000,  32'h80000000,  32'h40000000, 4, 1'b0, "mulh_min_min");
        run_op(OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 4, 1'b0, "mulhu_ff_ff");
        run_op(OP_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 4, 1'b0, "mulhsu_ff_ff");
        run_op(OP_MULH,   32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 4, 1'b0, "mulh_m1_1");

        // Cache: fill with MULHU, hit with MUL, miss on mode change, then hit again.
        run_op(OP_MULHU,  32'hFFFFFFFF,  32'h00000002,  32'h00000001, 4, 1'b0, "c_mulhu");
        run_op(OP_MUL,    32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFE, 2, 1'b0, "c_mul_hit");
        run_op(OP_MULH,   32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 4, 1'b0, "c_mulh_miss");
        run_op(OP_MUL,    32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFE, 2, 1'b0, "c_mul_hit2");
        run_op(OP_MULH,   32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 2, 1'b0, "c_mulh_hit");
        run_op(OP_MULHSU, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 4, 1'b0, "c_mulhsu_miss");

        // Kill during CALC.
        op    = OP_MUL;
        rs1   = 32'd5;
        rs2   = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        kill  = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("kill_calc_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        kill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("kill_calc_done", {31'd0, done}, 32'd0);
            check("kill_calc_stall_after", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;
        run_op(OP_MUL, 32'd5, 32'd5, 32'h00000019, 4, 1'b0, "mul_5x5_after_kill");

        // Kill in IDLE suppresses the start of that cycle.
        op    = OP_MUL;
        rs1   = 32'd9;
        rs2   = 32'd9;
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("kill_idle_done", {31'd0, done}, 32'd0);
            check("kill_idle_stall", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;

        // start held high across DONE: two ops back to back.
        run_op(OP_MUL, 32'd2, 32'd3, 32'h00000006, 4, 1'b1, "b2b_mul");
        first_done = last_done;
        run_op(OP_MULHU, 32'h80000000, 32'd4, 32'h00000002, 4, 1'b0, "b2b_mulhu");
        check("b2b_done_spacing", last_done - first_done, 32'd4);

        // Asynchronous reset during FIX.
        op    = OP_MUL;
        rs1   = 32'd3;
        rs2   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_fix_result", result, 32'h0);
        check("rst_fix_done", {31'd0, done}, 32'd0);
        check("rst_fix_result_nc", result_nc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nc_chk = 1'b1;
        run_op(OP_MUL, 32'd3, 32'd3, 32'h00000009, 4, 1'b0, "mul_3x3_after_rst");
        nc_chk = 1'b0;
        run_op(OP_MUL, 32'd3, 32'd3, 32'h00000009, 2, 1'b0, "mul_3x3_hit");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_results: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
